// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, stall and flush.
// Defining IF_ID_STAGE_PERF_CNT_EN adds saturating stall/flush performance counters.
module if_id_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] nextInstrAddr_i,
   input  logic [31:0] instr_i,
   input  logic        flush_i,
   input  logic        IDEX_memRead_i,
   input  logic [4:0]  IDEX_rt_i,
   output logic [31:0] instr_o,
   output logic [31:0] nextInstrAddr_o,
   output logic        valid_o,
   output logic        pcWrite_o,
   output logic        bubble_o,
   output logic [15:0] stallCount_o,
   output logic [15:0] flushCount_o
);

   logic [31:0] r_instr;
   logic [31:0] r_next_addr;
   logic        r_valid;
   logic        w_rs_match;
   logic        w_rt_match;
   logic        w_hazard;

   // Load-use hazard: the load in ID/EX writes a register the decoded instruction reads.
   always_comb begin
      w_rs_match = (IDEX_rt_i == r_instr[25:21]);
      w_rt_match = (IDEX_rt_i == r_instr[20:16]);
      w_hazard   = IDEX_memRead_i & r_valid & (IDEX_rt_i != 5'd0) & (w_rs_match | w_rt_match);
   end

   // Pipeline register: flush wins over stall, stall holds, otherwise load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_instr     <= 32'h0000_0000;
         r_next_addr <= 32'h0000_0000;
         r_valid     <= 1'b0;
      end else if (flush_i) begin
         r_instr     <= 32'h0000_0000;
         r_next_addr <= nextInstrAddr_i;
         r_valid     <= 1'b0;
      end else if (!w_hazard) begin
         r_instr     <= instr_i;
         r_next_addr <= nextInstrAddr_i;
         r_valid     <= 1'b1;
      end
   end

   assign instr_o         = r_instr;
   assign nextInstrAddr_o = r_next_addr;
   assign valid_o         = r_valid;
   assign pcWrite_o       = ~w_hazard;
   assign bubble_o        = w_hazard;

`ifdef IF_ID_STAGE_PERF_CNT_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   // Saturating counters; a flushed stall cycle counts as a flush only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else if (flush_i) begin
         if (r_flush_cnt != 16'hFFFF) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end else if (w_hazard) begin
         if (r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign stallCount_o = r_stall_cnt;
   assign flushCount_o = r_flush_cnt;
`else
   assign stallCount_o = 16'd0;
   assign flushCount_o = 16'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: vector table, scoreboard queue, reset and saturation sequences.
// Counter expectations follow IF_ID_STAGE_PERF_CNT_EN.
module tb_if_id_stage;

   logic        clk;
   logic        rst;
   logic [31:0] next_addr_in;
   logic [31:0] instr_in;
   logic        flush;
   logic        mem_rd;
   logic [4:0]  rt;
   logic [31:0] instr_out;
   logic [31:0] next_addr_out;
   logic        valid_out;
   logic        pc_write;
   logic        bubble;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   if_id_stage dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .nextInstrAddr_i (next_addr_in),
      .instr_i         (instr_in),
      .flush_i         (flush),
      .IDEX_memRead_i  (mem_rd),
      .IDEX_rt_i       (rt),
      .instr_o         (instr_out),
      .nextInstrAddr_o (next_addr_out),
      .valid_o         (valid_out),
      .pcWrite_o       (pc_write),
      .bubble_o        (bubble),
      .stallCount_o    (stall_cnt),
      .flushCount_o    (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [31:0] instr;
      logic [31:0] addr;
      logic        mem_rd;
      logic [4:0]  rt;
      logic        exp_haz;
      logic [31:0] exp_instr;
      logic [31:0] exp_addr;
      logic        exp_valid;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        valid;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];
   logic [15:0] model_stall;
   logic [15:0] model_flush;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, " instr_o"}, instr_out, e.instr);
      chk({tag, " nextInstrAddr_o"}, next_addr_out, e.addr);
      chk({tag, " valid_o"}, {31'd0, valid_out}, {31'd0, e.valid});
      chk({tag, " stallCount_o"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      chk({tag, " flushCount_o"}, {16'd0, flush_cnt}, {16'd0, e.flush});
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk_all(tag, e);
      end
   endtask

   initial begin
      exp_t e;
      //           flush instr          addr          rd   rt     haz   exp_instr      exp_addr      valid
      vecs[0]  = '{1'b0, 32'h8C22_0004, 32'h0000_0008, 1'b0, 5'd0, 1'b0, 32'h8C22_0004, 32'h0000_0008, 1'b1};
      vecs[1]  = '{1'b0, 32'h0043_0820, 32'h0000_000C, 1'b1, 5'd3, 1'b0, 32'h0043_0820, 32'h0000_000C, 1'b1};
      vecs[2]  = '{1'b0, 32'h0000_0001, 32'h0000_0010, 1'b1, 5'd2, 1'b1, 32'h0043_0820, 32'h0000_000C, 1'b1};
      vecs[3]  = '{1'b0, 32'h0003_1020, 32'h0000_0010, 1'b0, 5'd2, 1'b0, 32'h0003_1020, 32'h0000_0010, 1'b1};
      vecs[4]  = '{1'b0, 32'h8C44_0008, 32'h0000_0014, 1'b1, 5'd0, 1'b0, 32'h8C44_0008, 32'h0000_0014, 1'b1};
      vecs[5]  = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0018, 1'b1, 5'd4, 1'b1, 32'h0000_0000, 32'h0000_0018, 1'b0};
      vecs[6]  = '{1'b0, 32'h8C85_0000, 32'h0000_001C, 1'b1, 5'd4, 1'b0, 32'h8C85_0000, 32'h0000_001C, 1'b1};
      vecs[7]  = '{1'b0, 32'h1111_1111, 32'h0000_0020, 1'b1, 5'd5, 1'b1, 32'h8C85_0000, 32'h0000_001C, 1'b1};
      vecs[8]  = '{1'b0, 32'h2222_2222, 32'h0000_0024, 1'b1, 5'd4, 1'b1, 32'h8C85_0000, 32'h0000_001C, 1'b1};
      vecs[9]  = '{1'b1, 32'h3333_3333, 32'h0000_0024, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 32'h0000_0024, 1'b0};
      vecs[10] = '{1'b1, 32'h4444_4444, 32'h0000_0028, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 32'h0000_0028, 1'b0};
      vecs[11] = '{1'b0, 32'h0123_4567, 32'h0000_002C, 1'b0, 5'd9, 1'b0, 32'h0123_4567, 32'h0000_002C, 1'b1};
      vecs[12] = '{1'b0, 32'h5555_5555, 32'h0000_0030, 1'b1, 5'd9, 1'b1, 32'h0123_4567, 32'h0000_002C, 1'b1};

      rst = 1'b1; flush = 1'b0; mem_rd = 1'b1; rt = 5'd1;
      instr_in = 32'hFFFF_FFFF; next_addr_in = 32'h0000_0004;
      model_stall = 16'd0; model_flush = 16'd0;

      // reset state, including hazard suppression while valid_o is low
      #12;
      e = '{32'h0, 32'h0, 1'b0, 16'd0, 16'd0};
      chk_all("reset", e);
      chk("reset pcWrite_o", {31'd0, pc_write}, 32'd1);
      chk("reset bubble_o", {31'd0, bubble}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         flush = vecs[i].flush; instr_in = vecs[i].instr; next_addr_in = vecs[i].addr;
         mem_rd = vecs[i].mem_rd; rt = vecs[i].rt;
         #1;
         chk($sformatf("v%0d pcWrite_o", i), {31'd0, pc_write}, {31'd0, ~vecs[i].exp_haz});
         chk($sformatf("v%0d bubble_o", i), {31'd0, bubble}, {31'd0, vecs[i].exp_haz});
`ifdef IF_ID_STAGE_PERF_CNT_EN
         if (vecs[i].flush) model_flush = model_flush + 16'd1;
         else if (vecs[i].exp_haz) model_stall = model_stall + 16'd1;
`endif
         sb.push_back('{vecs[i].exp_instr, vecs[i].exp_addr, vecs[i].exp_valid, model_stall, model_flush});
         @(posedge clk);
         #1;
         pop_check($sformatf("v%0d", i));
      end

      // async reset while a stall is in progress
      @(negedge clk);
      flush = 1'b0; mem_rd = 1'b1; rt = 5'd3;
      #1;
      chk("pre-reset bubble_o", {31'd0, bubble}, 32'd1);
      rst = 1'b1;
      #1;
      e = '{32'h0, 32'h0, 1'b0, 16'd0, 16'd0};
      chk_all("async reset", e);
      chk("async reset pcWrite_o", {31'd0, pc_write}, 32'd1);
      chk("async reset bubble_o", {31'd0, bubble}, 32'd0);
      #1;
      rst = 1'b0;
      mem_rd = 1'b0; instr_in = 32'hCAFE_F00D; next_addr_in = 32'h0000_0040;
      sb.push_back('{32'hCAFE_F00D, 32'h0000_0040, 1'b1, 16'd0, 16'd0});
      @(posedge clk);
      #1;
      pop_check("post-reset load");

`ifdef IF_ID_STAGE_PERF_CNT_EN
      // flush counter saturates rather than wrapping
      @(negedge clk);
      flush = 1'b1;
      repeat (65537) @(posedge clk);
      #1;
      chk("saturated flushCount_o", {16'd0, flush_cnt}, 32'h0000_FFFF);
      chk("saturated stallCount_o", {16'd0, stall_cnt}, 32'h0000_0000);
      @(negedge clk);
      flush = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port nextInstrAddr_i, input, 32 bits: PC+4 from fetch.
REQ-004 SHALL have port instr_i, input, 32 bits: fetched instruction word.
REQ-005 SHALL have port flush_i, input, 1 bit: taken branch/jump resolved in decode; discard the fetched instruction.
REQ-006 SHALL have port IDEX_memRead_i, input, 1 bit: the instruction in the ID/EX stage is a load.
REQ-007 SHALL have port IDEX_rt_i, input, 5 bits: destination rt of that load.
REQ-008 SHALL have port instr_o, output, 32 bits: registered instruction for decode.
REQ-009 SHALL have port nextInstrAddr_o, output, 32 bits: registered PC+4 for decode.
REQ-010 SHALL have port valid_o, output, 1 bit: instr_o holds a real, unflushed instruction.
REQ-011 SHALL have port pcWrite_o, output, 1 bit: PC update enable to fetch; 0 during stall.
REQ-012 SHALL have port bubble_o, output, 1 bit: the ID/EX control inputs are zeroed this cycle.
REQ-013 SHALL have ports stallCount_o and flushCount_o, outputs, 16 bits each: performance counters (see Configuration).

Function
REQ-014 SHALL compute hazard combinationally from registered state and current inputs only:
- IDEX_memRead_i=1
- valid_o=1
- IDEX_rt_i!=0
- IDEX_rt_i equals instr_o[25:21] or instr_o[20:16]
REQ-015 SHALL drive pcWrite_o = ~hazard and bubble_o = hazard, with no registered delay.
REQ-016 SHALL, on each rising edge, apply these cases in priority order:
- flush_i=1: instr_o<=0x00000000 (nop), valid_o<=0, nextInstrAddr_o<=nextInstrAddr_i.
- else hazard=1: hold instr_o, nextInstrAddr_o and valid_o unchanged.
- else: instr_o<=instr_i, nextInstrAddr_o<=nextInstrAddr_i, valid_o<=1.
REQ-017 SHALL have a latency of exactly one cycle from fetch inputs to outputs when neither stall nor flush is active.
REQ-018 SHALL give flush priority over a simultaneous hazard: the stalled instruction is discarded, and the cycle after the flush has hazard=0 because valid_o=0.
REQ-019 SHALL deassert hazard by construction after one stall cycle for a single load-use pair, because the load advances out of ID/EX and a bubble takes its place.
REQ-020 SHALL never assert hazard for IDEX_rt_i=0, including on the nop produced by reset or flush.

Reset
REQ-021 SHALL, while rst_i=1, asynchronously force instr_o=0, nextInstrAddr_o=0, valid_o=0, stallCount_o=0 and flushCount_o=0.
REQ-022 SHALL, during reset, hold pcWrite_o=1 and bubble_o=0, since valid_o=0 forces hazard=0.
REQ-023 SHALL, when reset is asserted mid-stall or mid-flush, abandon that operation immediately; the first rising edge after rst_i falls behaves as a normal load.

Configuration
REQ-024 SHALL, with macro IF_ID_STAGE_PERF_CNT_EN defined, implement both counters:
- stallCount_o increments on each edge where hazard=1 and flush_i=0.
- flushCount_o increments on each edge where flush_i=1.
- Both saturate at 0xFFFF and do not wrap.
REQ-025 SHALL, with the macro undefined, implement no counter flops and tie stallCount_o and flushCount_o to 0; all other behaviour is identical.

Verification
REQ-026 SHALL cover the normal flow: after reset, instr_i=0x8C220004 and nextInstrAddr_i=0x00000008 for one edge -> instr_o=0x8C220004, nextInstrAddr_o=0x00000008, valid_o=1 one cycle later.
REQ-027 SHALL cover load-use: instr_o=0x00430820 (add $1,$2,$3), IDEX_memRead_i=1, IDEX_rt_i=2 -> pcWrite_o=0 and bubble_o=1; outputs held for one edge; stallCount_o=1 with the macro enabled.
REQ-028 SHALL cover a false dependence: same instruction with IDEX_rt_i=0, or with IDEX_memRead_i=0 -> pcWrite_o=1, bubble_o=0, next instruction loaded.
REQ-029 SHALL cover flush during stall: hazard=1 and flush_i=1 on the same edge -> instr_o=0, valid_o=0, flushCount_o=1, stallCount_o unchanged; the next cycle has pcWrite_o=1.
REQ-030 SHALL cover asynchronous reset: assert rst_i between edges while valid_o=1 -> all outputs reach reset values before the next edge.
REQ-031 SHALL cover saturation: drive flush_i=1 for 65537 edges (macro defined) -> flushCount_o=0xFFFF; rebuild without the macro -> both counters read 0.
